// File: rtl/fft_pkg.sv
// Shared constants, address/twiddle types and FSM states for the FFT scheduler.
// Imported by fft_addr_gen and fft_sched.
package fft_pkg;
   localparam int LOG2N = 12;
   localparam int N     = 1 << LOG2N;

   typedef logic [LOG2N-1:0] addr_t;
   typedef logic [LOG2N-2:0] tw_t;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fsm_t;
endpackage

// File: rtl/fft_addr_gen.sv
// Maps (stage, butterfly j) to the radix-2 DIT address pair and twiddle index.
// Outputs are combinational; tw_q keeps the twiddle of the last loaded read.
module fft_addr_gen #(
   parameter int LOG2N = fft_pkg::LOG2N
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ld,
   input  logic [3:0]       stage,
   input  logic [LOG2N-2:0] j,
   output logic [LOG2N-1:0] addr_a,
   output logic [LOG2N-1:0] addr_b,
   output logic [LOG2N-2:0] tw,
   output logic [LOG2N-2:0] tw_q
);
   import fft_pkg::*;

   logic [LOG2N-1:0] jx;
   logic [LOG2N-1:0] span;
   logic [LOG2N-1:0] lo;
   logic [LOG2N-1:0] hi;

   // Insert a zero bit at position stage into j; partner has that bit set.
   always_comb begin
      jx     = {1'b0, j};
      span   = LOG2N'(1) << stage;
      lo     = jx & (span - LOG2N'(1));
      hi     = jx >> stage;
      addr_a = (hi << (stage + 4'd1)) | lo;
      addr_b = addr_a | span;
      tw     = lo[LOG2N-2:0] << (4'(LOG2N - 1) - stage);
   end

   // Hold the twiddle of the issued read until its data returns.
   always_ff @(posedge clk) begin
      if (!rst_n) tw_q <= '0;
      else if (ld) tw_q <= tw;
   end
endmodule

// File: rtl/fft_sched.sv
// Radix-2 in-place DIT FFT scheduler: alternating read/write slots per stage.
// Optional build macro FFT_SCHED_CYCCNT_EN adds the cycle_cnt busy counter.
module fft_sched #(
   parameter int LOG2N  = fft_pkg::LOG2N,
   parameter int BF_LAT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [3:0]       stage,
   output logic             we_a,
   output logic [LOG2N-1:0] addr_a,
   output logic             we_b,
   output logic [LOG2N-1:0] addr_b,
   output logic             bf_in_valid,
   output logic [LOG2N-2:0] tw_idx
`ifdef FFT_SCHED_CYCCNT_EN
   ,
   output logic [31:0]      cycle_cnt
`endif
);
   import fft_pkg::*;

   localparam int D  = 1 + BF_LAT;
   localparam int HW = LOG2N - 1;
   localparam logic [HW-1:0] JLAST = '1;

   if (BF_LAT % 2 != 0) begin : g_lat_chk
      $error("fft_sched: BF_LAT must be even");
   end

   fsm_t            state;
   logic [3:0]      stg;
   logic [HW-1:0]   j;
   logic            phase;
   logic            rd_vis;
   logic            rd_go;
   logic            wr_go;
   logic [LOG2N-1:0] ga;
   logic [LOG2N-1:0] gb;
   logic [HW-1:0]   gtw;
   logic [HW-1:0]   tw_q;

   logic            pv [D];
   logic            pl [D];
   logic [LOG2N-1:0] pa [D];
   logic [LOG2N-1:0] pb [D];

   fft_addr_gen #(.LOG2N(LOG2N)) u_gen (
      .clk    (clk),
      .rst_n  (rst_n),
      .ld     (rd_go),
      .stage  (stg),
      .j      (j),
      .addr_a (ga),
      .addr_b (gb),
      .tw     (gtw),
      .tw_q   (tw_q)
   );

   // Slot decode: a read issues on start or on an even RUN slot.
   always_comb begin
      rd_go = ((state == RUN) && !phase) || ((state == IDLE) && start);
      wr_go = ((state == RUN) || (state == DRAIN)) && phase && pv[D-1];
   end

   // Main FSM, delay pipe and registered RAM/butterfly controls.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         stg         <= '0;
         j           <= '0;
         phase       <= 1'b0;
         rd_vis      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         stage       <= '0;
         we_a        <= 1'b0;
         we_b        <= 1'b0;
         addr_a      <= '0;
         addr_b      <= '0;
         bf_in_valid <= 1'b0;
         tw_idx      <= '0;
         for (int i = 0; i < D; i++) begin
            pv[i] <= 1'b0;
            pl[i] <= 1'b0;
            pa[i] <= '0;
            pb[i] <= '0;
         end
      end else begin
         for (int i = D - 1; i > 0; i--) begin
            pv[i] <= pv[i-1];
            pl[i] <= pl[i-1];
            pa[i] <= pa[i-1];
            pb[i] <= pb[i-1];
         end
         pv[0]       <= 1'b0;
         pl[0]       <= 1'b0;
         we_a        <= 1'b0;
         we_b        <= 1'b0;
         done        <= 1'b0;
         rd_vis      <= 1'b0;
         bf_in_valid <= rd_vis;
         if (rd_vis) tw_idx <= tw_q;

         if (rd_go) begin
            addr_a <= ga;
            addr_b <= gb;
            pv[0]  <= 1'b1;
            pl[0]  <= (j == JLAST);
            pa[0]  <= ga;
            pb[0]  <= gb;
            rd_vis <= 1'b1;
            stage  <= stg;
            j      <= j + HW'(1);
         end

         if (wr_go) begin
            we_a   <= 1'b1;
            we_b   <= 1'b1;
            addr_a <= pa[D-1];
            addr_b <= pb[D-1];
         end

         unique case (state)
            IDLE: begin
               if (start) begin
                  state <= RUN;
                  busy  <= 1'b1;
                  phase <= 1'b1;
               end
            end
            RUN, DRAIN: begin
               phase <= ~phase;
               if (rd_go && (j == JLAST)) state <= DRAIN;
               if (wr_go && pl[D-1]) begin
                  j <= '0;
                  if (stg == 4'(LOG2N - 1)) begin
                     state <= DONE;
                     stg   <= '0;
                  end else begin
                     state <= RUN;
                     stg   <= stg + 4'd1;
                  end
               end
            end
            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef FFT_SCHED_CYCCNT_EN
   // Busy-cycle counter; cleared on launch, frozen after done.
   always_ff @(posedge clk) begin
      if (!rst_n) cycle_cnt <= '0;
      else if ((state == IDLE) && start) cycle_cnt <= '0;
      else if (busy) cycle_cnt <= cycle_cnt + 32'd1;
   end
`endif
endmodule

// File: tb/tb_fft_sched.sv
// Self-checking bench for fft_sched: cycle-level schedule model plus literals.
// Define FFT_SCHED_CYCCNT_EN to also check cycle_cnt.
module tb_fft_sched;
   import fft_pkg::*;

   localparam int LG    = 12;
   localparam int L     = 4;
   localparam int NN    = 1 << LG;
   localparam int HALF  = NN / 2;
   localparam int SL    = NN + L;
   localparam int TOTAL = LG * SL;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          busy, done, we_a, we_b, bf_in_valid;
   logic [3:0]    stage;
   logic [LG-1:0] addr_a, addr_b;
   logic [LG-2:0] tw_idx;
`ifdef FFT_SCHED_CYCCNT_EN
   logic [31:0]   cycle_cnt;
`endif

   int checks = 0;
   int errors = 0;

   fft_sched #(.LOG2N(LG), .BF_LAT(L)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .stage       (stage),
      .we_a        (we_a),
      .addr_a      (addr_a),
      .we_b        (we_b),
      .addr_b      (addr_b),
      .bf_in_valid (bf_in_valid),
      .tw_idx      (tw_idx)
`ifdef FFT_SCHED_CYCCNT_EN
      ,
      .cycle_cnt   (cycle_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Address of the lower element of butterfly j in stage s.
   function automatic int pair_lo(int s, int jj);
      int span;
      span = 1 << s;
      return (jj / span) * (2 * span) + (jj % span);
   endfunction

   function automatic int pair_tw(int s, int jj);
      return (jj % (1 << s)) * (HALF >> s);
   endfunction

   int mode = 0;
   int k = 0;
   int e_busy = 0, e_done = 0, e_stage = 0, e_we = 0;
   int e_a = 0, e_b = 0, e_bfv = 0, e_tw = 0, e_cnt = 0;
   int wcnt [NN];
   logic s_r, s_st;

   task automatic run_cycle();
      int s, c, jj;
      s = k / SL;
      c = k % SL;
      e_busy = 1;
      e_done = 0;
      e_stage = s;
      e_we = 0;
      e_bfv = 0;
      e_cnt = k;
      if (c % 2 == 0) begin
         if (c / 2 < HALF) begin
            e_a = pair_lo(s, c / 2);
            e_b = e_a + (1 << s);
         end
      end else begin
         if (c >= 1 + L) begin
            jj = (c - 1 - L) / 2;
            e_we = 1;
            e_a = pair_lo(s, jj);
            e_b = e_a + (1 << s);
         end
         if ((c - 1) / 2 < HALF) begin
            e_bfv = 1;
            e_tw = pair_tw(s, (c - 1) / 2);
         end
      end
   endtask

   // Model step on inputs sampled at posedge; compare at the following negedge.
   always begin : cmp
      @(posedge clk);
      s_r = rst_n;
      s_st = start;
      @(negedge clk);
      if (!s_r) begin
         mode = 0;
         e_busy = 0; e_done = 0; e_stage = 0; e_we = 0;
         e_a = 0; e_b = 0; e_bfv = 0; e_tw = 0; e_cnt = 0;
      end else if (mode == 1) begin
         k++;
         if (k == TOTAL) begin
            mode = 2;
            e_busy = 0; e_done = 1; e_we = 0; e_bfv = 0;
            e_cnt = TOTAL;
         end else begin
            run_cycle();
         end
      end else begin
         e_done = 0;
         mode = 0;
         if (s_st) begin
            mode = 1;
            k = 0;
            run_cycle();
         end
      end
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("stage", stage, e_stage);
      chk("we_a", we_a, e_we);
      chk("we_b", we_b, e_we);
      chk("addr_a", addr_a, e_a);
      chk("addr_b", addr_b, e_b);
      chk("bf_in_valid", bf_in_valid, e_bfv);
      chk("tw_idx", tw_idx, e_tw);
`ifdef FFT_SCHED_CYCCNT_EN
      chk("cycle_cnt", cycle_cnt, e_cnt);
`endif
      if (we_a || we_b) chk("we_addr_distinct", addr_a != addr_b, 1);
      if (we_a) wcnt[addr_a]++;
      if (we_b) wcnt[addr_b]++;
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      int busy_n, weseen, bad, done_at;
      bit seen;

      chk("m_s0j0", pair_lo(0, 0), 0);
      chk("m_s0j1", pair_lo(0, 1), 2);
      chk("m_s1j1", pair_lo(1, 1), 1);
      chk("m_s1j1_tw", pair_tw(1, 1), 1024);
      chk("m_s11j5", pair_lo(11, 5) + 2048, 2053);
      chk("m_s11j5_tw", pair_tw(11, 5), 5);

      rst_n = 1'b0;
      start = 1'b0;
      repeat (3) tick();
      chk("rst_busy", busy, 0);
      chk("rst_addr_a", addr_a, 0);
      rst_n = 1'b1;
      repeat ($urandom_range(2, 8)) tick();

      // Short run abandoned by reset after 100 cycles.
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (99) tick();
      rst_n = 1'b0;
      tick();
      chk("midrst_busy", busy, 0);
      chk("midrst_we", {we_a, we_b}, 0);
      chk("midrst_stage", stage, 0);
      rst_n = 1'b1;
      weseen = 0;
      for (int i = 0; i < 20; i++) begin
         start = 1'b0;
         tick();
         if (we_a || we_b) weseen++;
      end
      chk("post_rst_no_we", weseen, 0);

      // Full transform; start randomly wiggled, then held to force a restart.
      for (int i = 0; i < NN; i++) wcnt[i] = 0;
      start = 1'b1;
      tick();
      chk("j0_addr_a", addr_a, 0);
      chk("j0_addr_b", addr_b, 1);
      chk("j0_we", {we_a, we_b}, 0);
      busy_n = busy ? 1 : 0;
      seen = 1'b0;
      done_at = -1;
      for (int i = 1; i < TOTAL + 50; i++) begin
         start = (i >= TOTAL - 10) ? 1'b1 : 1'($urandom_range(0, 1));
         tick();
         if (busy) busy_n++;
         if (i == 1) chk("j0_tw", {bf_in_valid, tw_idx}, {1'b1, 11'd0});
         if (i == 2) chk("j1_pair", {addr_a, addr_b}, {12'd2, 12'd3});
         if (i == 5) chk("j0_write", {we_a, we_b, addr_a, addr_b},
                         {1'b1, 1'b1, 12'd0, 12'd1});
         if (i == SL - 1) chk("s0_last_wr", {we_a, stage}, {1'b1, 4'd0});
         if (i == SL) chk("s1_first_rd", {we_a, stage, addr_a, addr_b},
                          {1'b0, 4'd1, 12'd0, 12'd2});
         if (i == SL + 3) chk("s1j1_tw", tw_idx, 1024);
         if (i == 11 * SL + 10)
            chk("s11j5_pair", {addr_a, addr_b}, {12'd5, 12'd2053});
         if (i == 11 * SL + 11) chk("s11j5_tw", tw_idx, 5);
         if (done) begin
            seen = 1'b1;
            done_at = i;
            break;
         end
      end
      chk("done_seen", seen, 1);
      chk("done_at", done_at, TOTAL);
      chk("busy_len", busy_n, TOTAL);
`ifdef FFT_SCHED_CYCCNT_EN
      chk("cnt_at_done", cycle_cnt, TOTAL);
`endif
      bad = 0;
      for (int a = 0; a < NN; a++) if (wcnt[a] != LG) bad++;
      chk("wr_count_bad", bad, 0);

      tick();
      chk("restart_busy", busy, 1);
      chk("restart_done", done, 0);
      repeat ($urandom_range(50, 300)) begin
         start = 1'($urandom_range(0, 1));
         tick();
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      start = 1'b0;
      repeat (10) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
